// File: rtl/seg7_scan_mux_if.sv
// rtl/seg7_scan_mux_if.sv - producer-to-display bundle for the four-digit scan multiplexer
interface seg7_scan_mux_if;
  logic        en;
  logic [15:0] digits;
  logic [3:0]  dp;
  logic        blank_lz;
  logic [3:0]  bcd;
  logic [3:0]  anode_n;
  logic        dp_n;
  logic        frame_tick;

  // Producer side: drives digits and controls, observes the display drive.
  modport master (
    output en, digits, dp, blank_lz,
    input  bcd, anode_n, dp_n, frame_tick
  );

  // Scanner side.
  modport slave (
    input  en, digits, dp, blank_lz,
    output bcd, anode_n, dp_n, frame_tick
  );
endinterface

// File: rtl/seg7_scan_mux.sv
// rtl/seg7_scan_mux.sv - four-digit time-multiplexed 7-segment scanner with guard time and blanking
module seg7_scan_mux #(
  parameter int DIV   = 50000,
  parameter int GUARD = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  seg7_scan_mux_if.slave bus
);

  localparam int            CW      = $clog2(DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);
  localparam logic [CW-1:0] GUARD_C = CW'(GUARD);

  logic [CW-1:0] cnt, cnt_nxt;
  logic [1:0]    slot, slot_nxt;
  logic [15:0]   sh_dig, sh_dig_nxt;
  logic [3:0]    sh_dp, sh_dp_nxt;
  logic          sh_blz, sh_blz_nxt;
  logic          load_pend, load_pend_nxt;
  logic          load;

  logic [3:0]    sd;
  logic [3:0]    zero;
  logic          lead_zero;
  logic          lit;
  logic [3:0]    bcd_nxt;
  logic [3:0]    anode_nxt;
  logic          dp_n_nxt;

  // Next scan position and shadow contents; shadow only changes on a load edge.
  always_comb begin
    load          = bus.en && (load_pend || (slot == 2'd3 && cnt == CNT_MAX));
    cnt_nxt       = cnt;
    slot_nxt      = slot;
    sh_dig_nxt    = sh_dig;
    sh_dp_nxt     = sh_dp;
    sh_blz_nxt    = sh_blz;
    load_pend_nxt = load_pend;
    if (bus.en) begin
      if (cnt == CNT_MAX) begin
        cnt_nxt  = '0;
        slot_nxt = slot + 2'd1;
      end else begin
        cnt_nxt = cnt + CW'(1);
      end
    end
    if (load) begin
      sh_dig_nxt    = bus.digits;
      sh_dp_nxt     = bus.dp;
      sh_blz_nxt    = bus.blank_lz;
      load_pend_nxt = 1'b0;
    end
  end

  // Display drive for the state being entered, so the output flops track it cycle for cycle.
  always_comb begin
    sd = 4'd0;
    case (slot_nxt)
      2'd0:    sd = sh_dig_nxt[3:0];
      2'd1:    sd = sh_dig_nxt[7:4];
      2'd2:    sd = sh_dig_nxt[11:8];
      default: sd = sh_dig_nxt[15:12];
    endcase
    zero[0] = (sh_dig_nxt[3:0]   == 4'd0) && !sh_dp_nxt[0];
    zero[1] = (sh_dig_nxt[7:4]   == 4'd0) && !sh_dp_nxt[1];
    zero[2] = (sh_dig_nxt[11:8]  == 4'd0) && !sh_dp_nxt[2];
    zero[3] = (sh_dig_nxt[15:12] == 4'd0) && !sh_dp_nxt[3];
    // Digit 0 is never suppressed so an all-zero value still shows "0".
    lead_zero = 1'b0;
    case (slot_nxt)
      2'd1:    lead_zero = &zero[3:1];
      2'd2:    lead_zero = &zero[3:2];
      2'd3:    lead_zero = zero[3];
      default: lead_zero = 1'b0;
    endcase
    lit       = bus.en && (cnt_nxt >= GUARD_C) && (sd <= 4'd9) && !(sh_blz_nxt && lead_zero);
    bcd_nxt   = sd;
    anode_nxt = 4'hF;
    dp_n_nxt  = 1'b1;
    if (lit) begin
      anode_nxt = ~(4'b0001 << slot_nxt);
      dp_n_nxt  = ~sh_dp_nxt[slot_nxt];
    end
  end

  // Scan state, shadow register and registered display outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt            <= '0;
      slot           <= 2'd0;
      sh_dig         <= 16'd0;
      sh_dp          <= 4'd0;
      sh_blz         <= 1'b0;
      load_pend      <= 1'b1;
      bus.bcd        <= 4'd0;
      bus.anode_n    <= 4'hF;
      bus.dp_n       <= 1'b1;
      bus.frame_tick <= 1'b0;
    end else begin
      cnt            <= cnt_nxt;
      slot           <= slot_nxt;
      sh_dig         <= sh_dig_nxt;
      sh_dp          <= sh_dp_nxt;
      sh_blz         <= sh_blz_nxt;
      load_pend      <= load_pend_nxt;
      bus.bcd        <= bcd_nxt;
      bus.anode_n    <= anode_nxt;
      bus.dp_n       <= dp_n_nxt;
      bus.frame_tick <= load;
    end
  end

endmodule

// File: doc/seg7_scan_mux.md
# seg7_scan_mux

Four-digit time-multiplexed scanner sitting directly upstream of the BCD-to-7-segment decoder. Takes four BCD digits plus decimal points from the counter/datapath, latches them once per frame, and presents one digit at a time on `bcd[3:0]` to the decoder while driving the matching active-low common anode. Provides anti-ghosting guard time, leading-zero blanking, and a frame-boundary pulse for the upstream producer.

## Interface
- `DIV`, 50000: clock cycles per digit slot; legal range 4 to 2^20.
- `GUARD`, 4: cycles at the start of each slot with all anodes off; legal range 1 to DIV-2.
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `en`  in  1  scan enable; low freezes scanning and blanks the display.
- `digits`  in  16  four BCD digits; `[3:0]` = digit 0 (least significant), `[15:12]` = digit 3.
- `dp`  in  4  decimal point request per digit; bit i = digit i.
- `blank_lz`  in  1  enable leading-zero suppression.
- `bcd`  out  4  BCD code to decoder; `bcd[0]` drives decoder A (LSB), `bcd[3]` drives D (MSB).
- `anode_n`  out  4  active-low digit enables; bit i = digit i.
- `dp_n`  out  1  active-low decimal point segment.
- `frame_tick`  out  1  one-cycle pulse when the shadow register loads.

## Operation
- State: prescaler `cnt` (0..DIV-1), slot index `slot` (0..3), 16+4+1-bit shadow of `digits`/`dp`/`blank_lz`, flag `load_pend`.
- While `en`=1, `cnt` increments every cycle. At `cnt`=DIV-1 it wraps to 0 and `slot` advances 0→1→2→3→0. While `en`=0, `cnt` and `slot` hold.
- Shadow load occurs on the edge where `en`=1 and either `load_pend`=1 or (`slot`=3 and `cnt`=DIV-1). `load_pend` clears on that edge. `frame_tick`=1 for exactly the cycle after each load edge.
- The shadowed digit for the current slot is `sd`. The slot is blanked if any of these hold:
  - `sd` > 9.
  - Leading zero: shadowed `blank_lz`=1, slot ≥ 1, and every shadowed digit from 3 down to this slot is 0 with its dp bit clear.
- Digit 0 is never leading-zero blanked, so 0000 displays "0".
- Outputs are flops whose value equals the function of the same-cycle `cnt`/`slot`/shadow state:
  - `bcd` = `sd`, even when the slot is blanked.
  - `anode_n` = all ones if `en`=0, `cnt` < GUARD, or the slot is blanked. Otherwise only bit `slot` is low.
  - `dp_n` = ~shadowed dp[`slot`] while that anode is on, else 1.
- Input changes between load edges have no visible effect, so there is no tearing within a frame.

## Timing
- Reset (asynchronous assert, clocked release):
  - `cnt`=0, `slot`=0, shadow=0, `load_pend`=1.
  - `bcd`=0, `anode_n`=4'b1111, `dp_n`=1, `frame_tick`=0.
- Reset asserted mid-slot forces the reset values immediately, without waiting for a clock edge.
- First load: the first edge with `en`=1 after reset release. `frame_tick` is high the following cycle.
- Slot period is DIV cycles. Frame period is 4·DIV cycles. `frame_tick` period is 4·DIV cycles.
- Within a slot, the anode is low for cycles `cnt`=GUARD..DIV-1, i.e. DIV-GUARD cycles.
- `en` deasserted mid-slot: all anodes go off on the next edge and `cnt`/`slot` freeze. On reassert, scanning resumes from the frozen `cnt`/`slot` with no reload unless `load_pend`=1.
- Simultaneous input change and load edge: the value present at that edge is captured.

## Test plan
- DIV=8, GUARD=2; reset, `en`=1, `digits`=16'h1234, `dp`=0:
  - `frame_tick` pulses once.
  - Slots 0..3 show `bcd`=4,3,2,1 with `anode_n`=1110,1101,1011,0111.
  - Each anode is low 6 of 8 cycles; `frame_tick` period is 32 cycles.
- `digits`=16'h0070, `blank_lz`=1:
  - Digits 3 and 2 stay blanked (`anode_n` bit high).
  - Digit 1 shows 7; digit 0 shows 0.
  - With `dp`=4'b0100, digit 2 lights with `bcd`=0 and `dp_n`=0.
- Change `digits` from 16'h1234 to 16'h5678 at slot 1: the display stays 1234 until the next `frame_tick`, then shows 5678.
- `digits`=16'h00A5: the digit 1 slot is blanked (invalid code) and digit 0 shows 5.
- Drop `en` at slot 2, `cnt`=5, for 10 cycles: `anode_n`=1111 and `cnt`/`slot` hold; after reassert, slot 2 continues from `cnt`=5.
- Assert `rst_n`=0 mid-slot between clock edges: outputs return to reset values immediately. After release, a reload occurs on the first enabled edge.
